// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported DataMemory.
// Each access runs IDLE -> BUSY (memory strobe) -> DONE (ack), one request at a time.
module dmem_arbiter #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [WIDTH-1:0]  a_wdata,
    input  logic [2:0]        a_funct3,
    output logic              a_ack,
    output logic              a_err,
    output logic [WIDTH-1:0]  a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [WIDTH-1:0]  b_wdata,
    input  logic [2:0]        b_funct3,
    output logic              b_ack,
    output logic              b_err,
    output logic [WIDTH-1:0]  b_rdata,

    output logic [ADDR_W-1:0] mem_adder,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    output logic [WIDTH-1:0]  mem_data_in,
    output logic [2:0]        mem_function3,
    input  logic [WIDTH-1:0]  mem_data_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic               last_grant;
    logic               grant;
    logic               lat_we;
    logic [ADDR_W-1:0]  lat_addr;
    logic [WIDTH-1:0]   lat_wdata;
    logic [2:0]         lat_funct3;
    logic               legal;
    logic               pick_b;
    logic               in_busy;

    // Grant/last_grant encoding: 0 = port A, 1 = port B.
    always_comb begin
        pick_b = 1'b0;
        if (a_req && b_req) begin
            pick_b = ~last_grant;
        end else if (b_req) begin
            pick_b = 1'b1;
        end
    end

    always_comb begin
        legal = 1'b0;
        if (lat_we) begin
            legal = (lat_funct3 == 3'b000) || (lat_funct3 == 3'b001) ||
                    (lat_funct3 == 3'b010);
        end else begin
            legal = (lat_funct3 == 3'b000) || (lat_funct3 == 3'b001) ||
                    (lat_funct3 == 3'b010) || (lat_funct3 == 3'b100) ||
                    (lat_funct3 == 3'b101);
        end
    end

    // Strobes are gated by rst so a reset landing in BUSY cannot commit a store.
    assign in_busy       = (state == BUSY) && !rst;
    assign mem_MemWrite  = in_busy && lat_we && legal;
    assign mem_MemRead   = in_busy && !lat_we && legal;
    assign mem_adder     = lat_addr;
    assign mem_data_in   = lat_wdata;
    assign mem_function3 = lat_funct3;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_funct3 <= 3'b000;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_err      <= 1'b0;
            b_err      <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            a_err <= 1'b0;
            b_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        grant      <= pick_b;
                        last_grant <= pick_b;
                        lat_we     <= pick_b ? b_we     : a_we;
                        lat_addr   <= pick_b ? b_addr   : a_addr;
                        lat_wdata  <= pick_b ? b_wdata  : a_wdata;
                        lat_funct3 <= pick_b ? b_funct3 : a_funct3;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (grant) begin
                        b_ack <= 1'b1;
                        b_err <= ~legal;
                        if (legal && !lat_we) begin
                            b_rdata <= mem_data_out;
                        end
                    end else begin
                        a_ack <= 1'b1;
                        a_err <= ~legal;
                        if (legal && !lat_we) begin
                            a_rdata <= mem_data_out;
                        end
                    end
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
